// File: rtl/d_phy_clk_lane_ctrl_pkg.sv
// Shared types and default timing values for the D-PHY master clock-lane sequencer.
//   t_clk_lane_ctrl_state : FSM state encoding, also exported on state_o for debug
//   *_DEF                 : default cycle counts for the sequencer parameters
//   is_wait_state()       : states that wait on a PHY handshake and run the timeout
package d_phy_clk_lane_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_INIT     = 4'd1,
    ST_STOP     = 4'd2,
    ST_HS_START = 4'd3,
    ST_HS_ON    = 4'd4,
    ST_HS_STOP  = 4'd5,
    ST_IDLE_IN  = 4'd6,
    ST_IDLE     = 4'd7,
    ST_IDLE_OUT = 4'd8,
    ST_ULPS_IN  = 4'd9,
    ST_ULPS     = 4'd10,
    ST_ULPS_OUT = 4'd11,
    ST_ULPS_END = 4'd12,
    ST_ERR      = 4'd13
  } t_clk_lane_ctrl_state;

  localparam int unsigned GAP_CYC_DEF      = 4;
  localparam int unsigned IDLE_MIN_CYC_DEF = 8;
  localparam int unsigned TIMEOUT_CYC_DEF  = 4096;
  localparam int unsigned CNT_W_DEF        = 13;

  function automatic logic is_wait_state(input t_clk_lane_ctrl_state s);
    return s inside {ST_INIT, ST_HS_START, ST_HS_STOP, ST_IDLE_IN, ST_IDLE_OUT,
                     ST_ULPS_IN, ST_ULPS_OUT, ST_ULPS_END};
  endfunction

endpackage

// File: rtl/d_phy_clk_lane_ctrl_cyc.sv
// Saturating cycle counter with synchronous clear and an expiry compare.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count from zero (wins over inc_i)
//   inc_i        : advance by one; holds at all-ones instead of wrapping
//   lim_i        : expiry threshold
//   exp_o        : count has reached lim_i
module d_phy_cyc_cnt #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] lim_i,
  output logic             exp_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign exp_o = (cnt_q >= lim_i);

endmodule

// File: rtl/d_phy_clk_lane_ctrl.sv
// PPI-side sequencer for the MIPI D-PHY master clock lane. Converts level requests
// from the link layer into the PPI clock-lane handshakes (HS start/stop, HS idle
// clock, ULPS entry/exit), enforces the STOP dwell and the idle hold time, and
// flags a sticky error when the PHY fails to answer within TIMEOUT_CYC cycles.
//   clk, rst            : TxWordClkHS, asynchronous active-high reset
//   en/hs_req/idle_req/ulps_req : level requests from the link layer
//   ppi_* outputs       : registered PPI controls towards the clock-lane PHY
//   ppi_* inputs        : PHY status (Stopstate, TxReadyHS, idle ready, UlpsActiveNot)
//   clk_ready           : HS clock running, data lanes may enter HS
//   err                 : sticky PHY timeout, cleared only by rst
//   state_o             : current state code
module d_phy_clk_lane_ctrl
  import d_phy_clk_lane_ctrl_pkg::*;
#(
  parameter int unsigned GAP_CYC      = GAP_CYC_DEF,
  parameter int unsigned IDLE_MIN_CYC = IDLE_MIN_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hs_req,
  input  logic       idle_req,
  input  logic       ulps_req,
  output logic       ppi_enable,
  output logic       ppi_tx_request_hs,
  output logic       ppi_tx_hs_idle_clk_hs,
  output logic       ppi_tx_ulps_clk,
  output logic       ppi_tx_ulps_exit,
  input  logic       ppi_stopstate,
  input  logic       ppi_tx_ready_hs,
  input  logic       ppi_tx_hs_idle_clk_ready_hs,
  input  logic       ppi_ulps_active_not,
  output logic       clk_ready,
  output logic       err,
  output logic [3:0] state_o
);

  t_clk_lane_ctrl_state state_q, state_d;
  logic                 enable_q, req_hs_q, idle_clk_q, ulps_clk_q, ulps_exit_q;
  logic                 clk_ready_q, err_q;
  logic                 cnt_clr, cnt_inc, cnt_exp;
  logic [CNT_W-1:0]     cnt_lim;

  // STOP dwell, IDLE hold and PHY timeout never overlap in time, so one counter
  // serves all three; the threshold follows the current state. Thresholds are
  // count-1 because the counter reads zero during the first cycle of a state.
  always_comb begin
    cnt_lim = CNT_W'(TIMEOUT_CYC - 1);
    unique case (state_q)
      ST_STOP: cnt_lim = CNT_W'(GAP_CYC - 1);
      ST_IDLE: cnt_lim = CNT_W'(IDLE_MIN_CYC - 1);
      default: cnt_lim = CNT_W'(TIMEOUT_CYC - 1);
    endcase
  end

  assign cnt_clr = (state_d != state_q) || !en;
  assign cnt_inc = (state_q == ST_STOP) || (state_q == ST_IDLE) || is_wait_state(state_q);

  d_phy_cyc_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .lim_i (cnt_lim),
    .exp_o (cnt_exp)
  );

  // In a wait state the PHY answer is checked before the timeout, so a reply
  // arriving on the last permitted cycle is still accepted.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF:      state_d = ST_INIT;
        ST_INIT:     if (ppi_stopstate) state_d = ST_STOP;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_STOP:     if (cnt_exp && hs_req) state_d = ST_HS_START;
                     else if (cnt_exp && ulps_req) state_d = ST_ULPS_IN;
        ST_HS_START: if (ppi_tx_ready_hs) state_d = ST_HS_ON;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_HS_ON:    if (!hs_req) state_d = ST_HS_STOP;
                     else if (idle_req) state_d = ST_IDLE_IN;
        ST_HS_STOP:  if (!ppi_tx_ready_hs && ppi_stopstate) state_d = ST_STOP;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_IDLE_IN:  if (ppi_tx_hs_idle_clk_ready_hs) state_d = ST_IDLE;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_IDLE:     if (cnt_exp && !idle_req) state_d = ST_IDLE_OUT;
        ST_IDLE_OUT: if (!ppi_tx_hs_idle_clk_ready_hs && ppi_tx_ready_hs) state_d = ST_HS_ON;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_ULPS_IN:  if (!ppi_ulps_active_not) state_d = ST_ULPS;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_ULPS:     if (!ulps_req) state_d = ST_ULPS_OUT;
        ST_ULPS_OUT: if (ppi_ulps_active_not) state_d = ST_ULPS_END;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_ULPS_END: if (ppi_stopstate) state_d = ST_STOP;
                     else if (cnt_exp) state_d = ST_ERR;
        ST_ERR:      state_d = ST_ERR;
        default:     state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      enable_q    <= 1'b0;
      req_hs_q    <= 1'b0;
      idle_clk_q  <= 1'b0;
      ulps_clk_q  <= 1'b0;
      ulps_exit_q <= 1'b0;
      clk_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= (state_d != ST_OFF) && (state_d != ST_ERR);
      req_hs_q    <= state_d inside {ST_HS_START, ST_HS_ON, ST_IDLE_IN, ST_IDLE, ST_IDLE_OUT};
      idle_clk_q  <= state_d inside {ST_IDLE_IN, ST_IDLE};
      ulps_clk_q  <= state_d inside {ST_ULPS_IN, ST_ULPS, ST_ULPS_OUT};
      ulps_exit_q <= (state_d == ST_ULPS_OUT);
      clk_ready_q <= (state_d == ST_HS_ON);
      err_q       <= err_q || (state_d == ST_ERR);
    end
  end

  assign ppi_enable            = enable_q;
  assign ppi_tx_request_hs     = req_hs_q;
  assign ppi_tx_hs_idle_clk_hs = idle_clk_q;
  assign ppi_tx_ulps_clk       = ulps_clk_q;
  assign ppi_tx_ulps_exit      = ulps_exit_q;
  assign clk_ready             = clk_ready_q;
  assign err                   = err_q;
  assign state_o               = state_q;

  a_hs_ulps_excl: assert property (@(posedge clk) disable iff (rst)
    !(ppi_tx_request_hs && ppi_tx_ulps_clk));
  a_idle_needs_hs: assert property (@(posedge clk) disable iff (rst)
    ppi_tx_hs_idle_clk_hs |-> ppi_tx_request_hs);

endmodule

// File: tb/tb_d_phy_clk_lane_ctrl.sv
// Bench for d_phy_clk_lane_ctrl with a small clock-lane PHY model (fixed 3-cycle
// response latency). Expected state sequences are queued by each scenario and
// consumed by a monitor whenever state_o changes.
module tb_d_phy_clk_lane_ctrl;
  import d_phy_clk_lane_ctrl_pkg::*;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, hs_req = 1'b0, idle_req = 1'b0, ulps_req = 1'b0;
  logic ppi_enable, ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs, ppi_tx_ulps_clk, ppi_tx_ulps_exit;
  logic ppi_stopstate, ppi_tx_ready_hs, ppi_tx_hs_idle_clk_ready_hs, ppi_ulps_active_not;
  logic clk_ready, err;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int model_err = 0;
  logic [3:0] sb_q[$];
  logic [3:0] last_st = 4'd0;
  logic [3:0] exp_st;
  bit saw_req_hs, saw_ulps_clk;
  logic stuck_hs = 1'b0;

  always #5 clk = ~clk;

  d_phy_clk_lane_ctrl #(.GAP_CYC(4), .IDLE_MIN_CYC(8), .TIMEOUT_CYC(TMO), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .en(en), .hs_req(hs_req), .idle_req(idle_req), .ulps_req(ulps_req),
    .ppi_enable(ppi_enable), .ppi_tx_request_hs(ppi_tx_request_hs),
    .ppi_tx_hs_idle_clk_hs(ppi_tx_hs_idle_clk_hs), .ppi_tx_ulps_clk(ppi_tx_ulps_clk),
    .ppi_tx_ulps_exit(ppi_tx_ulps_exit), .ppi_stopstate(ppi_stopstate),
    .ppi_tx_ready_hs(ppi_tx_ready_hs), .ppi_tx_hs_idle_clk_ready_hs(ppi_tx_hs_idle_clk_ready_hs),
    .ppi_ulps_active_not(ppi_ulps_active_not), .clk_ready(clk_ready), .err(err), .state_o(state_o)
  );

  // PHY model: each status output follows its target after three clock edges.
  logic [2:0] st_sr, rdy_sr, idl_sr, uan_sr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_sr <= '0; rdy_sr <= '0; idl_sr <= '0; uan_sr <= '1;
    end else begin
      st_sr  <= {st_sr[1:0], ppi_enable && !ppi_tx_request_hs && !ppi_tx_ulps_clk};
      rdy_sr <= {rdy_sr[1:0], ppi_tx_request_hs && !stuck_hs};
      idl_sr <= {idl_sr[1:0], ppi_tx_hs_idle_clk_hs && ppi_tx_request_hs};
      uan_sr <= {uan_sr[1:0], !(ppi_tx_ulps_clk && !ppi_tx_ulps_exit)};
    end
  end
  assign ppi_stopstate               = st_sr[2];
  assign ppi_tx_ready_hs             = rdy_sr[2];
  assign ppi_tx_hs_idle_clk_ready_hs = idl_sr[2];
  assign ppi_ulps_active_not         = uan_sr[2];

  // Model-side protocol checks and activity flags.
  always @(negedge clk) begin
    if (!rst) begin
      if (ppi_tx_hs_idle_clk_hs && !ppi_tx_request_hs) model_err++;
      if (ppi_tx_request_hs && ppi_tx_ulps_clk) model_err++;
      if (ppi_tx_request_hs) saw_req_hs = 1'b1;
      if (ppi_tx_ulps_clk) saw_ulps_clk = 1'b1;
    end
  end

  // Scoreboard: every state change must match the next queued state.
  always @(negedge clk) begin
    if (rst) begin
      last_st = 4'd0;
    end else if (state_o !== last_st) begin
      last_st = state_o;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_state: unexpected state %0d, none queued", state_o);
      end else begin
        exp_st = sb_q.pop_front();
        if (state_o !== exp_st) begin
          errors++;
          $display("FAIL sb_state: got %0d expected %0d", state_o, exp_st);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input t_clk_lane_ctrl_state s);
    sb_q.push_back(4'(s));
  endtask

  task automatic wait_sb(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ppi_enable, ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs, ppi_tx_ulps_clk, ppi_tx_ulps_exit,
         clk_ready, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 0000000", {ppi_enable, ppi_tx_request_hs,
               ppi_tx_hs_idle_clk_hs, ppi_tx_ulps_clk, ppi_tx_ulps_exit, clk_ready, err});
    end
    checks++;
    if (state_o !== 4'(ST_OFF)) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    rst = 1'b0;
  endtask

  task automatic test_hs_start_stop();
    int stop_cyc = 0;
    bit ok;
    push(ST_INIT); push(ST_STOP); push(ST_HS_START); push(ST_HS_ON);
    en = 1'b1;
    hs_req = 1'b1;
    for (int i = 0; i < 100 && !ppi_tx_request_hs; i++) begin
      tick();
      if (state_o == 4'(ST_STOP)) stop_cyc++;
    end
    checks++;
    if (!ppi_tx_request_hs || stop_cyc != 4) begin
      errors++;
      $display("FAIL stop_dwell: req_hs=%0b after %0d STOP cycles, expected 1 after 4", ppi_tx_request_hs, stop_cyc);
    end
    for (int i = 0; i < 100 && !ppi_tx_ready_hs; i++) tick();
    checks++;
    if (clk_ready !== 1'b0) begin errors++; $display("FAIL clk_ready_lag: got %0b expected 0", clk_ready); end
    tick();
    checks++;
    if (clk_ready !== 1'b1) begin errors++; $display("FAIL clk_ready_rise: got %0b expected 1", clk_ready); end
    wait_sb(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hs_on_reach: got %0d expected 4", state_o); sb_q.delete(); end
    push(ST_HS_STOP); push(ST_STOP);
    hs_req = 1'b0;
    wait_sb(50, ok);
    checks++;
    if (!ok || ppi_stopstate !== 1'b1 || clk_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_stop: state %0d stopstate %0b clk_ready %0b expected 2 1 0", state_o, ppi_stopstate, clk_ready);
      sb_q.delete();
    end
  endtask

  task automatic test_idle();
    int idle_cyc = 0;
    int held = 0;
    bit ok;
    push(ST_HS_START); push(ST_HS_ON);
    hs_req = 1'b1;
    wait_sb(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_pre: got %0d expected 4", state_o); sb_q.delete(); end
    push(ST_IDLE_IN); push(ST_IDLE); push(ST_IDLE_OUT); push(ST_HS_ON);
    idle_req = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      if (i == 3) idle_req = 1'b0;
      tick();
      if (state_o == 4'(ST_IDLE)) idle_cyc++;
      if (ppi_tx_hs_idle_clk_hs && ppi_tx_hs_idle_clk_ready_hs) held++;
    end
    idle_req = 1'b0;
    checks++;
    if (idle_cyc != 8 || held < 8) begin
      errors++;
      $display("FAIL idle_hold: %0d IDLE cycles, %0d held, expected 8 and >=8", idle_cyc, held);
    end
    checks++;
    if (sb_q.size() != 0 || ppi_tx_ready_hs !== 1'b1 || clk_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_return: state %0d ready_hs %0b clk_ready %0b expected 4 1 1", state_o, ppi_tx_ready_hs, clk_ready);
      sb_q.delete();
    end
    checks++;
    if (model_err != 0) begin errors++; $display("FAIL model_protocol: got %0d violations expected 0", model_err); end
    push(ST_HS_STOP); push(ST_STOP);
    hs_req = 1'b0;
    wait_sb(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_post_stop: got %0d expected 2", state_o); sb_q.delete(); end
  endtask

  task automatic test_ulps();
    bit ok;
    saw_req_hs = 1'b0;
    push(ST_ULPS_IN); push(ST_ULPS);
    ulps_req = 1'b1;
    wait_sb(50, ok);
    checks++;
    if (!ok || ppi_ulps_active_not !== 1'b0 || ppi_tx_ulps_clk !== 1'b1) begin
      errors++;
      $display("FAIL ulps_entry: state %0d uan %0b ulps_clk %0b expected 10 0 1", state_o, ppi_ulps_active_not, ppi_tx_ulps_clk);
      sb_q.delete();
    end
    push(ST_ULPS_OUT); push(ST_ULPS_END); push(ST_STOP);
    ulps_req = 1'b0;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      tick();
      if (state_o == 4'(ST_ULPS_OUT)) begin
        checks++;
        if (ppi_tx_ulps_exit !== 1'b1 || ppi_tx_ulps_clk !== 1'b1) begin
          errors++;
          $display("FAIL ulps_exit_pulse: exit %0b clk %0b expected 1 1", ppi_tx_ulps_exit, ppi_tx_ulps_clk);
        end
      end
      if (state_o == 4'(ST_ULPS_END)) begin
        checks++;
        if (ppi_tx_ulps_exit !== 1'b0 || ppi_tx_ulps_clk !== 1'b0) begin
          errors++;
          $display("FAIL ulps_end_drop: exit %0b clk %0b expected 0 0", ppi_tx_ulps_exit, ppi_tx_ulps_clk);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || saw_req_hs) begin
      errors++;
      $display("FAIL ulps_exit: state %0d saw_req_hs %0b expected 2 0", state_o, saw_req_hs);
      sb_q.delete();
    end
  endtask

  task automatic test_priority();
    bit ok;
    saw_ulps_clk = 1'b0;
    push(ST_HS_START); push(ST_HS_ON);
    hs_req = 1'b1;
    ulps_req = 1'b1;
    wait_sb(100, ok);
    checks++;
    if (!ok || saw_ulps_clk) begin
      errors++;
      $display("FAIL hs_priority: state %0d saw_ulps_clk %0b expected 4 0", state_o, saw_ulps_clk);
      sb_q.delete();
    end
    push(ST_HS_STOP); push(ST_STOP);
    hs_req = 1'b0;
    ulps_req = 1'b0;
    wait_sb(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL priority_stop: got %0d expected 2", state_o); sb_q.delete(); end
    // Fresh STOP entry: a 2-cycle pulse ends before the dwell and must be ignored.
    hs_req = 1'b1;
    tick();
    tick();
    hs_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (state_o !== 4'(ST_STOP) || ppi_tx_request_hs !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: state %0d req_hs %0b expected 2 0", state_o, ppi_tx_request_hs);
    end
  endtask

  task automatic test_disable();
    bit ok;
    push(ST_HS_START); push(ST_HS_ON);
    hs_req = 1'b1;
    wait_sb(100, ok);
    push(ST_OFF);
    en = 1'b0;
    tick();
    checks++;
    if (!ok || state_o !== 4'(ST_OFF) || {ppi_enable, ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs,
        ppi_tx_ulps_clk, ppi_tx_ulps_exit, clk_ready} !== 6'b0) begin
      errors++;
      $display("FAIL en_off_hs: state %0d outs %b expected 0 000000", state_o, {ppi_enable,
               ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs, ppi_tx_ulps_clk, ppi_tx_ulps_exit, clk_ready});
      sb_q.delete();
    end
    hs_req = 1'b0;
    push(ST_INIT); push(ST_STOP); push(ST_ULPS_IN); push(ST_ULPS);
    en = 1'b1;
    ulps_req = 1'b1;
    wait_sb(100, ok);
    push(ST_OFF);
    en = 1'b0;
    tick();
    checks++;
    if (!ok || state_o !== 4'(ST_OFF) || {ppi_enable, ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs,
        ppi_tx_ulps_clk, ppi_tx_ulps_exit, clk_ready} !== 6'b0) begin
      errors++;
      $display("FAIL en_off_ulps: state %0d outs %b expected 0 000000", state_o, {ppi_enable,
               ppi_tx_request_hs, ppi_tx_hs_idle_clk_hs, ppi_tx_ulps_clk, ppi_tx_ulps_exit, clk_ready});
      sb_q.delete();
    end
    ulps_req = 1'b0;
    push(ST_INIT); push(ST_STOP);
    en = 1'b1;
    wait_sb(100, ok);
    checks++;
    if (!ok || ppi_enable !== 1'b1) begin
      errors++;
      $display("FAIL reenable: state %0d enable %0b expected 2 1", state_o, ppi_enable);
      sb_q.delete();
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    push(ST_HS_START); push(ST_HS_ON);
    hs_req = 1'b1;
    wait_sb(100, ok);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!ok || {ppi_enable, ppi_tx_request_hs, clk_ready} !== 3'b0 || state_o !== 4'(ST_OFF)) begin
      errors++;
      $display("FAIL async_reset: enable/req/clk_ready %b state %0d expected 000 0",
               {ppi_enable, ppi_tx_request_hs, clk_ready}, state_o);
      sb_q.delete();
    end
    hs_req = 1'b0;
    tick();
    tick();
    push(ST_INIT); push(ST_STOP);
    rst = 1'b0;
    wait_sb(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_init: got %0d expected 2", state_o); sb_q.delete(); end
  endtask

  task automatic test_timeout();
    int start_cyc = 0;
    bit ok;
    stuck_hs = 1'b1;
    push(ST_HS_START); push(ST_ERR);
    hs_req = 1'b1;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      tick();
      if (state_o == 4'(ST_HS_START)) start_cyc++;
    end
    checks++;
    if (state_o !== 4'(ST_ERR) || start_cyc != int'(TMO)) begin
      errors++;
      $display("FAIL timeout: state %0d after %0d HS_START cycles, expected 13 after %0d", state_o, start_cyc, TMO);
      sb_q.delete();
    end
    checks++;
    if (err !== 1'b1 || {ppi_enable, ppi_tx_request_hs, ppi_tx_ulps_clk} !== 3'b0) begin
      errors++;
      $display("FAIL err_outs: err %0b outs %b expected 1 000", err, {ppi_enable, ppi_tx_request_hs, ppi_tx_ulps_clk});
    end
    hs_req = 1'b0;
    push(ST_OFF);
    en = 1'b0;
    wait_sb(20, ok);
    push(ST_INIT); push(ST_STOP);
    en = 1'b1;
    wait_sb(100, ok);
    checks++;
    if (!ok || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: state %0d err %0b expected 2 1", state_o, err);
      sb_q.delete();
    end
    stuck_hs = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0 || state_o !== 4'(ST_OFF)) begin
      errors++;
      $display("FAIL err_clear: err %0b state %0d expected 0 0", err, state_o);
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_hs_start_stop();
    test_idle();
    test_ulps();
    test_priority();
    test_disable();
    test_async_reset();
    test_timeout();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d states still queued, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
